instr_encoder: RTL and testbench
================================

# instr_encoder

Serialising writer for the Y86-64 instruction memory, the inverse of the fetch stage. Fetch splits memory bytes into icode/ifun/rA/rB/valC. This block takes those fields as one instruction, packs them into the canonical Y86-64 byte layout, and writes one byte per clock into the byte-wide instruction memory at a running write pointer. It is the program-load path feeding fetch.

## Interface
- ADDR_W, 10, instruction-memory byte-address width (1024 bytes)
- BASE_ADDR, 0, write-pointer value after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept an instruction this cycle
- icode  in  4  instruction code
- ifun  in  4  function code
- rA  in  4  register A
- rB  in  4  register B
- valC  in  64  constant / displacement / destination
- addr_load  in  1  load write pointer from addr_in (honoured only when in_ready=1)
- addr_in  in  ADDR_W  new write-pointer value
- mem_we  out  1  byte write strobe
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte data
- bad_instr  out  1  one-cycle pulse: accepted icode > 0xB, nothing written
- instr_count  out  16  count of instructions written, wraps at 2^16

## Operation
- States: IDLE, EMIT. Registers: wr_ptr, byte index k, length L, latched fields.
- Accept = in_valid & in_ready. On accept, fields are latched, L is computed and the FSM enters EMIT with k=0.
- Length and layout by icode. valC is always little-endian, byte 0 = valC[7:0].
  - 0 halt, 1 nop, 9 ret: L=1, byte {icode,4'h0}
  - 2 cmovXX, 6 OPq: L=2, bytes {icode,ifun}, {rA,rB}
  - A pushq, B popq: L=2, bytes {icode,4'h0}, {rA,4'hF}
  - 3 irmovq: L=10, bytes {3,0}, {4'hF,rB}, valC[7:0]..valC[63:56]
  - 4 rmmovq, 5 mrmovq: L=10, bytes {icode,0}, {rA,rB}, valC bytes
  - 7 jXX: L=9, bytes {7,ifun}, valC bytes
  - 8 call: L=9, bytes {8,0}, valC bytes
- ifun is forced to 0 for every icode except 2, 6 and 7. rA/rB are forced to F where the layout above shows F.
- icode C–F: the instruction is consumed, bad_instr pulses the next cycle, and the FSM stays IDLE. There is no write, and wr_ptr and instr_count are unchanged.
- EMIT, each cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=byte k. Then wr_ptr+=1 and k+=1. When k=L-1, instr_count+=1 and the FSM returns to IDLE unless a new accept happens in the same cycle.
- in_ready = (state==IDLE) | (state==EMIT & k==L-1). This gives gap-free back-to-back instructions.
- wr_ptr is modulo 2^ADDR_W: 2^ADDR_W-1 wraps to 0, including mid-instruction.
- addr_load with in_ready=1 sets wr_ptr=addr_in. If an accept happens in the same cycle, the new instruction is written from addr_in. addr_load with in_ready=0 is ignored.

## Timing
- All outputs are registered.
- Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, bad_instr=0, instr_count=0, in_ready=1 (state IDLE), wr_ptr=BASE_ADDR.
- Accept at edge N: byte 0 is written at edge N+1 and byte k at edge N+1+k. The last byte is written at N+L.
- Throughput: one instruction per L cycles. in_ready is low for cycles 1..L-1 of EMIT.
- Reset during EMIT: the remaining bytes are dropped and mem_we=0 from the next cycle. instr_count is not incremented for the partial instruction.
- mem_addr/mem_wdata hold their last value while mem_we=0.

## Test plan
- Reset then halt (icode 0, ifun 5): one write at edge N+1 of addr 0, data 0x00. instr_count=1; the ifun is not written.
- irmovq rB=3, valC=0x0123456789ABCDEF at ptr 0: ten writes to addr 0..9 of 30 F3 EF CD AB 89 67 45 23 01.
- Back-to-back with in_valid held high: OPq ifun=1 rA=2 rB=3, then jXX ifun=4 valC=0x40, then ret. Required: 61 23 74 40 00 00 00 00 00 00 00 90 at addr 0..11, mem_we high for 12 consecutive cycles, instr_count=3.
- addr_load addr_in=0x3FE with call valC=0x10 in the same cycle: writes to 0x3FE, 0x3FF, 0x000..0x006, data 80 10 00 00 00 00 00 00 00.
- icode=0xD: bad_instr pulses one cycle, no mem_we, wr_ptr and instr_count unchanged. A following nop is written at the unchanged pointer as 0x10.
- rst_n low at byte 4 of rmmovq: mem_we=0 next cycle, ptr=BASE_ADDR, instr_count=0, in_ready=1.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: Y86-64 instruction serialiser (program-load path feeding fetch).
// Takes one instruction as icode/ifun/rA/rB/valC, packs it into the canonical
// Y86-64 byte layout and writes it one byte per clock into a byte-wide memory
// at a running write pointer.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   instruction handshake; accept = in_valid & in_ready
//   icode, ifun, rA, rB   instruction fields
//   valC                  64-bit constant, emitted little-endian
//   addr_load, addr_in    reload the write pointer (only while in_ready=1)
//   mem_we, mem_addr,     byte write port; addr/data hold while mem_we=0
//   mem_wdata
//   bad_instr             one-cycle pulse after an accepted icode > 0xB
//   instr_count           instructions fully written, wraps at 2^16
module instr_encoder #(
    parameter int unsigned        ADDR_W    = 10,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              bad_instr,
    output logic [15:0]       instr_count
);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [3:0]        idx_q;
    logic [3:0]        len_q;
    logic [9:0][7:0]   buf_q;

    logic [9:0][7:0]   pack;
    logic [3:0]        pack_len;
    logic              pack_bad;
    logic              accept;
    logic              last;
    logic [3:0]        idx_nxt;
    logic [ADDR_W-1:0] start_ptr;

    assign accept    = in_valid & in_ready;
    assign last      = (state_q == StEmit) && (idx_q == len_q - 4'd1);
    assign idx_nxt   = idx_q + 4'd1;
    // A same-cycle addr_load redirects the instruction being accepted.
    assign start_ptr = (addr_load && in_ready) ? addr_in : wr_ptr_q;

    // Byte image of the presented instruction; ifun and unused registers are
    // forced to the canonical values here rather than trusted from the source.
    always_comb begin
        pack     = '0;
        pack_len = 4'd1;
        pack_bad = 1'b0;
        unique case (icode)
            4'h0, 4'h1, 4'h9: begin
                pack[0]  = {icode, 4'h0};
                pack_len = 4'd1;
            end
            4'h2, 4'h6: begin
                pack[0]  = {icode, ifun};
                pack[1]  = {rA, rB};
                pack_len = 4'd2;
            end
            4'hA, 4'hB: begin
                pack[0]  = {icode, 4'h0};
                pack[1]  = {rA, 4'hF};
                pack_len = 4'd2;
            end
            4'h3: begin
                pack[0]  = 8'h30;
                pack[1]  = {4'hF, rB};
                for (int i = 0; i < 8; i++) pack[i+2] = valC[8*i +: 8];
                pack_len = 4'd10;
            end
            4'h4, 4'h5: begin
                pack[0]  = {icode, 4'h0};
                pack[1]  = {rA, rB};
                for (int i = 0; i < 8; i++) pack[i+2] = valC[8*i +: 8];
                pack_len = 4'd10;
            end
            4'h7: begin
                pack[0]  = {4'h7, ifun};
                for (int i = 0; i < 8; i++) pack[i+1] = valC[8*i +: 8];
                pack_len = 4'd9;
            end
            4'h8: begin
                pack[0]  = 8'h80;
                for (int i = 0; i < 8; i++) pack[i+1] = valC[8*i +: 8];
                pack_len = 4'd9;
            end
            default: pack_bad = 1'b1;
        endcase
    end

    // Outputs are registered: the byte on mem_* during a cycle is the one the
    // memory captures at the end of that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= BASE_ADDR;
            idx_q       <= '0;
            len_q       <= 4'd1;
            buf_q       <= '0;
            in_ready    <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= BASE_ADDR;
            mem_wdata   <= '0;
            bad_instr   <= 1'b0;
            instr_count <= '0;
        end else begin
            bad_instr <= 1'b0;
            if (addr_load && in_ready) wr_ptr_q <= addr_in;
            if (last) instr_count <= instr_count + 16'd1;

            if (accept && !pack_bad) begin
                state_q   <= StEmit;
                idx_q     <= '0;
                len_q     <= pack_len;
                buf_q     <= pack;
                mem_we    <= 1'b1;
                mem_addr  <= start_ptr;
                mem_wdata <= pack[0];
                wr_ptr_q  <= start_ptr + 1'b1;
                in_ready  <= (pack_len == 4'd1);
            end else begin
                if (accept) bad_instr <= 1'b1;
                if (state_q == StEmit && !last) begin
                    idx_q     <= idx_nxt;
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_ptr_q;
                    mem_wdata <= buf_q[idx_nxt];
                    wr_ptr_q  <= wr_ptr_q + 1'b1;
                    in_ready  <= (idx_nxt == len_q - 4'd1);
                end else begin
                    state_q  <= StIdle;
                    mem_we   <= 1'b0;
                    in_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic        addr_load;
    logic [9:0]  addr_in;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        bad_instr;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [9:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];
    logic [9:0] exp_a [0:15];
    logic [7:0] exp_b [0:15];

    instr_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .addr_load   (addr_load),
        .addr_in     (addr_in),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .bad_instr   (bad_instr),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: sampled mid-cycle, each entry is a byte the memory captures.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic set_exp(input int i, input logic [9:0] a, input logic [7:0] b);
        exp_a[i] = a;
        exp_b[i] = b;
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] a,
                        input logic [3:0] b, input logic [63:0] c, input logic ld,
                        input logic [9:0] ad);
        int n = 0;
        in_valid  = 1'b1;
        icode     = ic;
        ifun      = f;
        rA        = a;
        rB        = b;
        valC      = c;
        addr_load = ld;
        addr_in   = ad;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        addr_load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_we && n < 100);
        if (n >= 100) check("idle_timeout", 64'(mem_we), 64'd0);
    endtask

    task automatic check_writes(input string tag, input int n);
        check($sformatf("%s_nwr", tag), 64'(wa.size()), 64'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wa[i]), 64'(exp_a[i]));
            check($sformatf("%s_data%0d", tag, i), 64'(wd[i]), 64'(exp_b[i]));
            check($sformatf("%s_cyc%0d", tag, i), 64'(wc[i] - wc[0]), 64'(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] v;
        rst_n = 1'b0; in_valid = 1'b0; icode = '0; ifun = '0; rA = '0; rB = '0;
        valC = '0; addr_load = 1'b0; addr_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_bad", 64'(bad_instr), 64'd0);
        check("rst_count", 64'(instr_count), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);

        // halt with nonzero ifun: single byte 0x00, first byte right after accept
        clear_log();
        send(4'h0, 4'h5, 4'h1, 4'h2, 64'h0, 1'b0, 10'h0);
        check("halt_we_n1", 64'(mem_we), 64'd1);
        check("halt_addr_n1", 64'(mem_addr), 64'd0);
        check("halt_ready_n1", 64'(in_ready), 64'd1);
        wait_idle();
        set_exp(0, 10'h0, 8'h00);
        check_writes("halt", 1);
        check("halt_count", 64'(instr_count), 64'd1);

        // irmovq rB=3 at ptr 0 (rA and ifun must be ignored)
        clear_log();
        send(4'h3, 4'h7, 4'h5, 4'h3, 64'h0123456789ABCDEF, 1'b1, 10'h0);
        wait_idle();
        v = 64'h0123456789ABCDEF;
        set_exp(0, 10'd0, 8'h30);
        set_exp(1, 10'd1, 8'hF3);
        for (int i = 0; i < 8; i++) set_exp(i + 2, 10'(i + 2), v[8*i +: 8]);
        check_writes("irmov", 10);
        check("irmov_count", 64'(instr_count), 64'd2);

        // back-to-back OPq, jXX, ret
        clear_log();
        send(4'h6, 4'h1, 4'h2, 4'h3, 64'hFFFF, 1'b1, 10'h0);
        send(4'h7, 4'h4, 4'h9, 4'h9, 64'h40, 1'b0, 10'h0);
        send(4'h9, 4'h3, 4'h1, 4'h1, 64'h0, 1'b0, 10'h0);
        wait_idle();
        set_exp(0, 10'd0, 8'h61);
        set_exp(1, 10'd1, 8'h23);
        set_exp(2, 10'd2, 8'h74);
        set_exp(3, 10'd3, 8'h40);
        for (int i = 4; i < 11; i++) set_exp(i, 10'(i), 8'h00);
        set_exp(11, 10'd11, 8'h90);
        check_writes("b2b", 12);
        check("b2b_count", 64'(instr_count), 64'd5);

        // addr_load + call, pointer wraps mid-instruction
        clear_log();
        send(4'h8, 4'h6, 4'h1, 4'h1, 64'h10, 1'b1, 10'h3FE);
        wait_idle();
        set_exp(0, 10'h3FE, 8'h80);
        set_exp(1, 10'h3FF, 8'h10);
        for (int i = 2; i < 9; i++) set_exp(i, 10'(i - 2), 8'h00);
        check_writes("call", 9);
        check("call_count", 64'(instr_count), 64'd6);

        // illegal icode: pulse, no write, then nop at unchanged ptr (7)
        clear_log();
        send(4'hD, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 10'h0);
        check("bad_pulse", 64'(bad_instr), 64'd1);
        check("bad_we", 64'(mem_we), 64'd0);
        @(posedge clk);
        #1;
        check("bad_clear", 64'(bad_instr), 64'd0);
        check("bad_count", 64'(instr_count), 64'd6);
        check("bad_nwr", 64'(wa.size()), 64'd0);
        send(4'h1, 4'h3, 4'h4, 4'h4, 64'h0, 1'b0, 10'h0);
        wait_idle();
        set_exp(0, 10'd7, 8'h10);
        check_writes("nop", 1);
        check("nop_count", 64'(instr_count), 64'd7);

        // reset while byte 4 of rmmovq is on the bus
        clear_log();
        send(4'h4, 4'h9, 4'h1, 4'h2, 64'h1122334455667788, 1'b0, 10'h0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rrst_we", 64'(mem_we), 64'd0);
        check("rrst_addr", 64'(mem_addr), 64'd0);
        check("rrst_count", 64'(instr_count), 64'd0);
        check("rrst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        set_exp(0, 10'd8, 8'h40);
        set_exp(1, 10'd9, 8'h12);
        set_exp(2, 10'd10, 8'h88);
        set_exp(3, 10'd11, 8'h77);
        set_exp(4, 10'd12, 8'h66);
        check_writes("rrst", 5);
        clear_log();
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 10'h0);
        wait_idle();
        set_exp(0, 10'd0, 8'h10);
        check_writes("post_rst", 1);
        check("post_rst_count", 64'(instr_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
